// File: rtl/pll_scan_ctrl_pkg.sv
// Shared constants and types for the PLL scan-chain controller.
// Video-mode encodings live here alongside the scan-chain defaults.
package pll_scan_ctrl_pkg;

    localparam int unsigned ADDR_W               = 8;
    localparam int unsigned SCAN_BITS_DEFAULT    = 144;
    localparam int unsigned ROM_LATENCY_DEFAULT  = 2;
    localparam int unsigned DONE_TIMEOUT_DEFAULT = 1024;

    typedef enum logic [1:0] {
        MODE_VGA,
        MODE_720P,
        MODE_1080P
    } video_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_SHIFT,
        ST_ARM,
        ST_UPDATE,
        ST_WAIT_DONE
    } scan_state_t;

endpackage

// File: rtl/pll_scan_ctrl_scan_shifter.sv
// Configuration buffer plus 2-clock scan serialiser (low phase, then high phase).
// buffer[0] goes out first; done is high during the final high phase.
module scan_shifter
    import pll_scan_ctrl_pkg::*;
#(
    parameter int unsigned SCAN_BITS = SCAN_BITS_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_data,
    input  logic              start,
    output logic              done,
    output logic              scanclk,
    output logic              scanclkena,
    output logic              scandata
);

    localparam int unsigned IDX_W = (SCAN_BITS > 1) ? $clog2(SCAN_BITS) : 1;

    logic [SCAN_BITS-1:0] buffer;
    logic                 active;
    logic                 phase;
    logic [IDX_W-1:0]     idx;
    logic                 last_bit;

    always_ff @(posedge clock) begin
        if (wr_en) begin
            buffer[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            active <= 1'b0;
            phase  <= 1'b0;
            idx    <= '0;
        end else if (start) begin
            active <= 1'b1;
            phase  <= 1'b0;
            idx    <= '0;
        end else if (active) begin
            phase <= ~phase;
            if (phase) begin
                if (last_bit) begin
                    active <= 1'b0;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
        end
    end

    // Data follows idx, which only moves when entering a low phase.
    assign last_bit   = (idx == IDX_W'(SCAN_BITS - 1));
    assign done       = active & phase & last_bit;
    assign scanclk    = phase;
    assign scanclkena = active;
    assign scandata   = active & buffer[idx];

endmodule

// File: rtl/pll_scan_ctrl.sv
// PLL scan-chain controller: fetches SCAN_BITS bits from the reconfig ROM,
// shifts them into the PLL, then issues configupdate and waits for scandone.
module pll_scan_ctrl
    import pll_scan_ctrl_pkg::*;
#(
    parameter int unsigned SCAN_BITS    = SCAN_BITS_DEFAULT,
    parameter int unsigned ROM_LATENCY  = ROM_LATENCY_DEFAULT,
    parameter int unsigned DONE_TIMEOUT = DONE_TIMEOUT_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              trigger_read,
    input  logic              rom_q,
    input  logic              reconfig,
    input  logic              pll_scandone,
    output logic [ADDR_W-1:0] rom_address,
    output logic              rom_read_ena,
    output logic              busy,
    output logic              pll_scanclk,
    output logic              pll_scanclkena,
    output logic              pll_scandata,
    output logic              pll_configupdate,
    output logic              error
);

    localparam int unsigned DRAIN_W = $clog2(ROM_LATENCY + 1);
    localparam int unsigned TMO_W   = $clog2(DONE_TIMEOUT + 1);

    if (SCAN_BITS < 1 || SCAN_BITS > 256 || ROM_LATENCY < 1) begin : g_bad_params
        $error("pll_scan_ctrl: SCAN_BITS must be 1..256 and ROM_LATENCY >= 1");
    end

    scan_state_t       state, state_next;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [TMO_W-1:0]   timeout_cnt;
    logic               pending;
    logic               scandone_prev;
    logic               scandone_rise;
    logic               timeout_hit;
    logic               fetch_last;
    logic               shift_start;
    logic               shift_done;
    logic [ADDR_W-1:0]  addr_pipe [ROM_LATENCY];
    logic [ROM_LATENCY-1:0] valid_pipe;

    assign fetch_last       = (rom_address == ADDR_W'(SCAN_BITS - 1));
    assign scandone_rise    = pll_scandone & ~scandone_prev;
    assign timeout_hit      = (timeout_cnt == TMO_W'(DONE_TIMEOUT - 1));
    assign rom_read_ena     = (state == ST_FETCH);
    assign pll_configupdate = (state == ST_UPDATE);

    always_comb begin
        state_next  = state;
        shift_start = 1'b0;
        unique case (state)
            ST_IDLE:      if (trigger_read) state_next = ST_FETCH;
            ST_FETCH:     if (fetch_last) state_next = ST_DRAIN;
            ST_DRAIN: begin
                if (drain_cnt == DRAIN_W'(ROM_LATENCY - 1)) begin
                    state_next  = ST_SHIFT;
                    shift_start = 1'b1;
                end
            end
            ST_SHIFT:     if (shift_done) state_next = ST_ARM;
            ST_ARM:       if (pending || reconfig) state_next = ST_UPDATE;
            ST_UPDATE:    state_next = ST_WAIT_DONE;
            ST_WAIT_DONE: if (scandone_rise || timeout_hit) state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    // Address pipe needs no reset: writes are qualified by valid_pipe.
    always_ff @(posedge clock) begin
        addr_pipe[0] <= rom_address;
        for (int unsigned i = 1; i < ROM_LATENCY; i++) begin
            addr_pipe[i] <= addr_pipe[i-1];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            busy          <= 1'b0;
            rom_address   <= '0;
            drain_cnt     <= '0;
            timeout_cnt   <= '0;
            pending       <= 1'b0;
            error         <= 1'b0;
            scandone_prev <= 1'b0;
            valid_pipe    <= '0;
        end else begin
            state         <= state_next;
            busy          <= (state_next != ST_IDLE);
            scandone_prev <= pll_scandone;
            valid_pipe[0] <= rom_read_ena;
            for (int unsigned i = 1; i < ROM_LATENCY; i++) begin
                valid_pipe[i] <= valid_pipe[i-1];
            end
            if (state != ST_IDLE && reconfig) begin
                pending <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (trigger_read) begin
                        rom_address <= '0;
                        error       <= 1'b0;
                        pending     <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    drain_cnt <= '0;
                    if (!fetch_last) begin
                        rom_address <= rom_address + ADDR_W'(1);
                    end
                end
                ST_DRAIN:  drain_cnt <= drain_cnt + DRAIN_W'(1);
                ST_UPDATE: begin
                    pending     <= 1'b0;
                    timeout_cnt <= TMO_W'(1);
                end
                ST_WAIT_DONE: begin
                    timeout_cnt <= timeout_cnt + TMO_W'(1);
                    if (timeout_hit && !scandone_rise) begin
                        error <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    scan_shifter #(
        .SCAN_BITS (SCAN_BITS)
    ) u_shifter (
        .clock      (clock),
        .reset      (reset),
        .wr_en      (valid_pipe[ROM_LATENCY-1]),
        .wr_addr    (addr_pipe[ROM_LATENCY-1]),
        .wr_data    (rom_q),
        .start      (shift_start),
        .done       (shift_done),
        .scanclk    (pll_scanclk),
        .scanclkena (pll_scanclkena),
        .scandata   (pll_scandata)
    );

endmodule

// File: tb/tb_pll_scan_ctrl.sv
// Self-checking bench for pll_scan_ctrl: ROM model, scan-chain monitor,
// idle vector table, directed corner sequences and randomized full sequences.
module tb_pll_scan_ctrl;

    localparam int N   = 144;
    localparam int L   = 2;
    localparam int TMO = 1024;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       trigger_read = 1'b0;
    logic       rom_q;
    logic       reconfig = 1'b0;
    logic       pll_scandone = 1'b0;
    logic [7:0] rom_address;
    logic       rom_read_ena, busy, pll_scanclk, pll_scanclkena, pll_scandata;
    logic       pll_configupdate, error;

    pll_scan_ctrl #(
        .SCAN_BITS    (N),
        .ROM_LATENCY  (L),
        .DONE_TIMEOUT (TMO)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .trigger_read     (trigger_read),
        .rom_q            (rom_q),
        .reconfig         (reconfig),
        .pll_scandone     (pll_scandone),
        .rom_address      (rom_address),
        .rom_read_ena     (rom_read_ena),
        .busy             (busy),
        .pll_scanclk      (pll_scanclk),
        .pll_scanclkena   (pll_scanclkena),
        .pll_scandata     (pll_scandata),
        .pll_configupdate (pll_configupdate),
        .error            (error)
    );

    always #5 clock = ~clock;

    // ROM: data for an address appears two clocks after it is presented.
    logic       rom_mem [256];
    logic [7:0] a1 = '0, a2 = '0;
    always @(posedge clock) begin
        a1 <= rom_address;
        a2 <= a1;
    end
    assign rom_q = rom_mem[a2];

    // Cycle counter and mid-cycle monitor of the ROM and scan interfaces.
    int   cyc = 0;
    int   addr_log[$];
    int   addr_cyc[$];
    logic cap[$];
    int   last_edge_cyc = -1;
    int   cu_count = 0;
    int   stab_err = 0;
    logic prev_sclk = 1'b0;
    logic low_data = 1'b0;

    always @(posedge clock) cyc = cyc + 1;

    always @(negedge clock) begin
        if (rom_read_ena) begin
            addr_log.push_back(int'(rom_address));
            addr_cyc.push_back(cyc);
        end
        if (pll_scanclk && !prev_sclk) begin
            cap.push_back(pll_scandata);
            last_edge_cyc = cyc;
            if (pll_scandata !== low_data) stab_err++;
        end
        if (!pll_scanclk) low_data = pll_scandata;
        prev_sclk = pll_scanclk;
        if (pll_configupdate) cu_count++;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_logs();
        addr_log.delete();
        addr_cyc.delete();
        cap.delete();
        last_edge_cyc = -1;
        cu_count = 0;
        stab_err = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        trigger_read = 1'b0;
        reconfig = 1'b0;
        pll_scandone = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Full load/shift/update sequence; sd_delay < 0 leaves scandone low for the timeout path.
    task automatic run_sequence(input int rec_delay, input int sd_delay, input int trig_addr);
        int f, fall, rcyc, cu, arm, exp_cu, mism, guard, ecyc;
        clear_logs();
        trigger_read = 1'b1;
        step();
        trigger_read = 1'b0;
        f = cyc;
        check("busy_after_trigger", busy, 1);
        fall = -1; rcyc = -1; cu = -1; guard = 0;
        while (cu < 0 && guard < 1500) begin
            if (fall < 0 && !rom_read_ena) fall = cyc;
            if (pll_configupdate) begin
                cu = cyc;
            end else begin
                reconfig = (fall >= 0 && cyc == fall + rec_delay);
                if (reconfig) rcyc = cyc;
                trigger_read = (trig_addr >= 0 && rom_read_ena && int'(rom_address) == trig_addr);
                step();
                guard++;
            end
        end
        reconfig = 1'b0;
        trigger_read = 1'b0;
        check("configupdate_seen", cu >= 0, 1);
        arm    = f + 3 * N + L;
        exp_cu = ((rcyc > arm) ? rcyc : arm) + 1;
        check("configupdate_cycle", cu, exp_cu);
        check("read_ena_fall_cycle", fall, f + N);
        check("addr_count", addr_log.size(), N);
        mism = 0;
        for (int i = 0; i < N; i++) begin
            if (i >= addr_log.size()) mism++;
            else if (addr_log[i] != i || addr_cyc[i] != f + i) mism++;
        end
        check("addr_sequence_errors", mism, 0);
        check("scan_edges", cap.size(), N);
        mism = 0;
        for (int i = 0; i < N; i++) begin
            if (i >= cap.size()) mism++;
            else if (cap[i] !== rom_mem[i]) mism++;
        end
        check("scan_data_errors", mism, 0);
        check("data_stability_errors", stab_err, 0);
        check("last_edge_cycle", last_edge_cyc, arm - 1);
        check("busy_in_update", busy, 1);
        if (sd_delay > 0) begin
            while (cyc < cu + sd_delay) step();
            check("busy_before_scandone", busy, 1);
            pll_scandone = 1'b1;
            step();
            check("busy_after_scandone", busy, 0);
            check("error_after_scandone", error, 0);
            pll_scandone = 1'b0;
            repeat (4) step();
            check("idle_stays_idle", {busy, rom_read_ena, pll_scanclkena}, 0);
            check("single_configupdate", cu_count, 1);
            check("single_fetch", addr_log.size(), N);
        end else begin
            ecyc = -1; guard = 0;
            while (ecyc < 0 && guard < TMO + 50) begin
                step();
                guard++;
                if (error) ecyc = cyc;
            end
            check("timeout_error_delay", ecyc - cu, TMO);
            check("busy_at_timeout", busy, 0);
            check("single_configupdate", cu_count, 1);
        end
    endtask

    typedef struct {
        logic       trig, rec, sd;
        logic       busy, rd, cu, sce, err;
        logic [7:0] addr;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int guard;
        logic [7:0] av;

        vecs[0] = '{0, 0, 0,  0, 0, 0, 0, 0, 8'd0};
        vecs[1] = '{0, 1, 0,  0, 0, 0, 0, 0, 8'd0};
        vecs[2] = '{0, 0, 1,  0, 0, 0, 0, 0, 8'd0};
        vecs[3] = '{0, 1, 1,  0, 0, 0, 0, 0, 8'd0};
        vecs[4] = '{1, 0, 0,  1, 1, 0, 0, 0, 8'd0};
        vecs[5] = '{0, 0, 0,  1, 1, 0, 0, 0, 8'd1};
        vecs[6] = '{1, 0, 0,  1, 1, 0, 0, 0, 8'd2};
        vecs[7] = '{0, 0, 0,  1, 1, 0, 0, 0, 8'd3};

        for (int a = 0; a < 256; a++) begin
            av = 8'(a);
            rom_mem[a] = av[0] ^ av[3];
        end

        do_reset();
        check("reset_outputs",
              {busy, rom_read_ena, pll_configupdate, pll_scanclk, pll_scanclkena,
               pll_scandata, error, rom_address}, 0);

        for (int i = 0; i < 8; i++) begin
            trigger_read = vecs[i].trig;
            reconfig     = vecs[i].rec;
            pll_scandone = vecs[i].sd;
            step();
            check($sformatf("vec%0d", i),
                  {busy, rom_read_ena, pll_configupdate, pll_scanclkena, error, rom_address},
                  {vecs[i].busy, vecs[i].rd, vecs[i].cu, vecs[i].sce, vecs[i].err, vecs[i].addr});
        end
        do_reset();

        run_sequence(2, 10, -1);
        run_sequence(2, 10, 50);

        run_sequence(2, -1, -1);
        trigger_read = 1'b1;
        step();
        trigger_read = 1'b0;
        check("error_cleared_by_trigger", {error, busy}, 2'b01);
        do_reset();

        clear_logs();
        trigger_read = 1'b1;
        step();
        trigger_read = 1'b0;
        guard = 0;
        while (cap.size() < 70 && guard < 2000) begin
            step();
            guard++;
        end
        check("reached_bit70", cap.size(), 70);
        #2 reset = 1'b1;
        #1;
        check("async_reset_outputs",
              {busy, rom_read_ena, pll_configupdate, pll_scanclk, pll_scanclkena,
               pll_scandata, error, rom_address}, 0);
        @(posedge clock);
        #1 reset = 1'b0;
        run_sequence(5, 10, -1);

        for (int it = 0; it < 6; it++) begin
            for (int a = 0; a < 256; a++) rom_mem[a] = 1'($urandom);
            run_sequence(int'($urandom_range(0, 420)), int'($urandom_range(1, 30)),
                         ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, N - 1)) : -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
